tile_sched: RTL and testbench

- Layer-level scheduler sitting above the per-tile compute controller.
- Accepts one GEMM command per valid/ready handshake and walks the N-tile × K-tile loop nest.
- For each tile it issues a one-cycle start to the compute controller, with weight-fill / weight-change flags and base addresses. It then waits for systolic completion.
- After the last K tile of each N tile, it hands the accumulator contents to writeback through a valid/ready handshake.

---
 rtl/tile_sched_pkg.sv | 16 +
 rtl/tile_addr_gen.sv | 39 +++
 rtl/tile_sched.sv | 125 ++++++++++++
 tb/tb_tile_sched.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tile_sched_pkg.sv
// tile_sched_pkg: shared widths, FSM state encoding and command record for tile_sched.
package tile_sched_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 16;
  localparam int SYS_ROW = 16;
  localparam int CNT_WIDTH = 8;
  typedef enum logic [2:0] {IDLE = 3'b000, ISSUE, WAIT, WB, FIN} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] num_row;
    logic [CNT_WIDTH-1:0] k_tiles;
    logic [CNT_WIDTH-1:0] n_tiles;
    logic [ADDR_WIDTH-1:0] in_base;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] out_base;
  } cmd_t;
endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: running input/weight/output address accumulators stepped by the scheduler FSM.
module tile_addr_gen
  import tile_sched_pkg::*;
(
  input logic clk,
  input logic rstn,
  input logic load,
  input logic step_k,
  input logic step_n,
  input cmd_t cmd,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] out_addr
);
  logic [ADDR_WIDTH-1:0] in_base, row;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_base <= '0;
      row <= '0;
      in_addr <= '0;
      w_addr <= '0;
      out_addr <= '0;
    end else if (load) begin
      in_base <= cmd.in_base;
      row <= ADDR_WIDTH'(cmd.num_row);
      in_addr <= cmd.in_base;
      w_addr <= cmd.w_base;
      out_addr <= cmd.out_base;
    end else if (step_k) begin
      in_addr <= in_addr + row;
      w_addr <= w_addr + ADDR_WIDTH'(SYS_ROW);
    end else if (step_n) begin
      // weight tiles are laid out n-major, so the weight pointer just keeps striding
      in_addr <= in_base;
      w_addr <= w_addr + ADDR_WIDTH'(SYS_ROW);
      out_addr <= out_addr + row;
    end
  end
endmodule

// File: rtl/tile_sched.sv
// tile_sched: N x K GEMM tile loop scheduler with writeback handshake; optional TILE_SCHED_PERF_EN perf counters.
module tile_sched
  import tile_sched_pkg::*;
(
  input logic clk,
  input logic rstn,
`ifdef TILE_SCHED_PERF_EN
  input logic perf_clr,
  output logic [31:0] perf_busy_cycles,
  output logic [31:0] perf_wb_stall,
`endif
  input logic cmd_valid,
  output logic cmd_ready,
  input logic [DATA_WIDTH-1:0] cmd_num_row,
  input logic [CNT_WIDTH-1:0] cmd_k_tiles,
  input logic [CNT_WIDTH-1:0] cmd_n_tiles,
  input logic [ADDR_WIDTH-1:0] cmd_in_base,
  input logic [ADDR_WIDTH-1:0] cmd_w_base,
  input logic [ADDR_WIDTH-1:0] cmd_out_base,
  output logic cc_en,
  output logic cc_weight_fill,
  output logic cc_weight_change,
  output logic [DATA_WIDTH-1:0] cc_num_row,
  output logic [ADDR_WIDTH-1:0] cc_in_addr,
  output logic [ADDR_WIDTH-1:0] cc_w_addr,
  output logic cc_accum_clear,
  input logic cc_sys_done,
  output logic wb_valid,
  input logic wb_ready,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_num_row,
  output logic busy,
  output logic done
);
  state_t state, nxt;
  logic [CNT_WIDTH-1:0] k, n, k_last, n_last, k_nx, n_nx, kl, nl;
  logic [DATA_WIDTH-1:0] row;
  logic load, step_k, step_n;
  cmd_t cmd;
  assign cmd = {cmd_num_row, cmd_k_tiles, cmd_n_tiles, cmd_in_base, cmd_w_base, cmd_out_base};
  assign cc_num_row = row;
  assign wb_num_row = row;
  tile_addr_gen u_addr (
    .clk(clk), .rstn(rstn), .load(load), .step_k(step_k), .step_n(step_n), .cmd(cmd),
    .in_addr(cc_in_addr), .w_addr(cc_w_addr), .out_addr(wb_addr)
  );
  always_comb begin
    nxt = state;
    load = 1'b0;
    step_k = 1'b0;
    step_n = 1'b0;
    case (state)
      IDLE: begin
        load = cmd_valid && cmd_ready;
        nxt = !load ? IDLE : (cmd_k_tiles == '0 || cmd_n_tiles == '0) ? FIN : ISSUE;
      end
      ISSUE: nxt = WAIT;
      WAIT: begin
        step_k = cc_sys_done && k != k_last;
        nxt = !cc_sys_done ? WAIT : step_k ? ISSUE : WB;
      end
      WB: begin
        step_n = wb_ready && n != n_last;
        nxt = !wb_ready ? WB : step_n ? ISSUE : FIN;
      end
      default: nxt = IDLE;
    endcase
    k_nx = (load || step_n) ? '0 : step_k ? k + 1'b1 : k;
    n_nx = load ? '0 : step_n ? n + 1'b1 : n;
    // on acceptance the limits are not captured yet, so take them from the command
    kl = load ? cmd_k_tiles - 1'b1 : k_last;
    nl = load ? cmd_n_tiles - 1'b1 : n_last;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      k <= '0;
      n <= '0;
      k_last <= '0;
      n_last <= '0;
      row <= '0;
      cc_en <= 1'b0;
      cc_weight_fill <= 1'b0;
      cc_weight_change <= 1'b0;
      cc_accum_clear <= 1'b0;
      wb_valid <= 1'b0;
      busy <= 1'b0;
      cmd_ready <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      k <= k_nx;
      n <= n_nx;
      if (load) begin
        k_last <= kl;
        n_last <= nl;
        row <= cmd_num_row;
      end
      cc_en <= nxt == ISSUE;
      if (nxt == ISSUE) begin
        cc_weight_fill <= k_nx == '0 && n_nx == '0;
        cc_weight_change <= !(k_nx == kl && n_nx == nl);
        cc_accum_clear <= k_nx == '0;
      end
      wb_valid <= nxt == WB;
      busy <= nxt != IDLE;
      cmd_ready <= nxt == IDLE;
      done <= state == FIN;
    end
  end
`ifdef TILE_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy_cycles <= '0;
      perf_wb_stall <= '0;
    end else if (perf_clr) begin
      perf_busy_cycles <= '0;
      perf_wb_stall <= '0;
    end else begin
      if (busy && !(&perf_busy_cycles)) perf_busy_cycles <= perf_busy_cycles + 1'b1;
      if (wb_valid && !wb_ready && !(&perf_wb_stall)) perf_wb_stall <= perf_wb_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_tile_sched.sv
// tb_tile_sched: table-driven directed checks of tile_sched (loop nest, addresses, flags, stalls, reset).
module tb_tile_sched;
  logic clk = 1'b0, rstn = 1'b0, cmd_valid = 1'b0, cc_sys_done = 1'b0, wb_ready = 1'b0;
  logic [15:0] cmd_num_row = '0, cmd_in_base = '0, cmd_w_base = '0, cmd_out_base = '0;
  logic [7:0] cmd_k_tiles = '0, cmd_n_tiles = '0;
  logic cmd_ready, cc_en, cc_weight_fill, cc_weight_change, cc_accum_clear, wb_valid, busy, done;
  logic [15:0] cc_num_row, cc_in_addr, cc_w_addr, wb_addr, wb_num_row;
`ifdef TILE_SCHED_PERF_EN
  logic perf_clr = 1'b0;
  logic [31:0] perf_busy_cycles, perf_wb_stall;
`endif
  int errors = 0, checks = 0;
  typedef struct {
    logic [15:0] row; logic [7:0] k, n; logic [15:0] ib, wbase, ob; int t0, w0, stall;
  } vec_t;
  typedef struct {logic [15:0] in, w; logic fill, chg, clr;} tile_t;
  vec_t tv[5];
  tile_t tl[11];
  logic [15:0] wa[7];

  tile_sched dut (
    .clk(clk), .rstn(rstn),
`ifdef TILE_SCHED_PERF_EN
    .perf_clr(perf_clr), .perf_busy_cycles(perf_busy_cycles), .perf_wb_stall(perf_wb_stall),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_row(cmd_num_row),
    .cmd_k_tiles(cmd_k_tiles), .cmd_n_tiles(cmd_n_tiles), .cmd_in_base(cmd_in_base),
    .cmd_w_base(cmd_w_base), .cmd_out_base(cmd_out_base), .cc_en(cc_en),
    .cc_weight_fill(cc_weight_fill), .cc_weight_change(cc_weight_change),
    .cc_num_row(cc_num_row), .cc_in_addr(cc_in_addr), .cc_w_addr(cc_w_addr),
    .cc_accum_clear(cc_accum_clear), .cc_sys_done(cc_sys_done), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_num_row(wb_num_row), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t v);
    int ti = v.t0;
    int wi = v.w0;
    cmd_num_row = v.row; cmd_k_tiles = v.k; cmd_n_tiles = v.n;
    cmd_in_base = v.ib; cmd_w_base = v.wbase; cmd_out_base = v.ob;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_num_row = 16'($urandom); cmd_k_tiles = 8'($urandom); cmd_n_tiles = 8'($urandom);
    cmd_in_base = 16'($urandom); cmd_w_base = 16'($urandom); cmd_out_base = 16'($urandom);
    chk("accepted", 32'({busy, cmd_ready}), 32'b10);
    if (v.k == 0 || v.n == 0) begin
      chk("zero_fin", 32'({busy, cc_en, wb_valid, done}), 32'b1000);
      tick();
      chk("zero_done", 32'({busy, done, cmd_ready, cc_en, wb_valid}), 32'b01100);
      tick();
      chk("zero_done_low", 32'(done), 32'd0);
      return;
    end
    for (int nn = 0; nn < int'(v.n); nn++) begin
      for (int kk = 0; kk < int'(v.k); kk++) begin
        chk($sformatf("cc_en t%0d", ti), 32'(cc_en), 32'd1);
        chk($sformatf("in t%0d", ti), 32'(cc_in_addr), 32'(tl[ti].in));
        chk($sformatf("w t%0d", ti), 32'(cc_w_addr), 32'(tl[ti].w));
        chk($sformatf("flags t%0d", ti), 32'({cc_weight_fill, cc_weight_change, cc_accum_clear}),
            32'({tl[ti].fill, tl[ti].chg, tl[ti].clr}));
        chk($sformatf("row t%0d", ti), 32'(cc_num_row), 32'(v.row));
        ti++;
        tick();
        chk("wait_en_low", 32'({cc_en, wb_valid}), 32'd0);
        tick();
        cc_sys_done = 1'b1;
        tick();
        cc_sys_done = 1'b0;
      end
      chk($sformatf("wb w%0d", wi), 32'({wb_valid, cc_en, wb_addr}), 32'({1'b1, 1'b0, wa[wi]}));
      chk($sformatf("wb_row w%0d", wi), 32'(wb_num_row), 32'(v.row));
      repeat (v.stall) begin
        cc_sys_done = 1'b1;
        tick();
        chk("wb_hold", 32'({wb_valid, cc_en, wb_addr}), 32'({1'b1, 1'b0, wa[wi]}));
      end
      cc_sys_done = 1'b0;
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk("wb_drop", 32'(wb_valid), 32'd0);
      wi++;
    end
    chk("fin", 32'({busy, done, wb_valid, cc_en}), 32'b1000);
    tick();
    chk("done", 32'({busy, done, cmd_ready}), 32'b011);
    tick();
    chk("done_low", 32'(done), 32'd0);
  endtask

  initial begin
    tv[0] = '{16'd8, 8'd1, 8'd1, 16'h0100, 16'h0200, 16'h0300, 0, 0, 0};
    tv[1] = '{16'd4, 8'd2, 8'd2, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0};
    tv[2] = '{16'd5, 8'd0, 8'd3, 16'h1000, 16'h2000, 16'h3000, 0, 0, 0};
    tv[3] = '{16'h10, 8'd3, 8'd1, 16'hFFF0, 16'hFFF0, 16'h0050, 5, 3, 10};
    tv[4] = '{16'd2, 8'd1, 8'd3, 16'h0007, 16'h0040, 16'hFFFE, 8, 4, 0};
    tl[0] = '{16'h0100, 16'h0200, 1'b1, 1'b0, 1'b1};
    tl[1] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1};
    tl[2] = '{16'h0004, 16'h0010, 1'b0, 1'b1, 1'b0};
    tl[3] = '{16'h0000, 16'h0020, 1'b0, 1'b1, 1'b1};
    tl[4] = '{16'h0004, 16'h0030, 1'b0, 1'b0, 1'b0};
    tl[5] = '{16'hFFF0, 16'hFFF0, 1'b1, 1'b1, 1'b1};
    tl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    tl[7] = '{16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0};
    tl[8] = '{16'h0007, 16'h0040, 1'b1, 1'b1, 1'b1};
    tl[9] = '{16'h0007, 16'h0050, 1'b0, 1'b1, 1'b1};
    tl[10] = '{16'h0007, 16'h0060, 1'b0, 1'b0, 1'b1};
    wa = '{16'h0300, 16'h0000, 16'h0004, 16'h0050, 16'hFFFE, 16'h0000, 16'h0002};
    repeat (2) tick();
    chk("rst_ctl", 32'({cmd_ready, cc_en, cc_weight_fill, cc_weight_change, cc_accum_clear, wb_valid, busy, done}), 32'd0);
    chk("rst_addr", 32'({cc_in_addr, cc_w_addr}), 32'd0);
    rstn = 1'b1;
    tick();
    chk("idle", 32'({cmd_ready, busy}), 32'b10);
    for (int i = 0; i < 5; i++) begin
      cc_sys_done = 1'b1;
      tick();
      cc_sys_done = 1'b0;
      chk("idle_spurious", 32'({cc_en, cmd_ready, busy}), 32'b010);
`ifdef TILE_SCHED_PERF_EN
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
`endif
      run(tv[i]);
`ifdef TILE_SCHED_PERF_EN
      chk("perf_wb_stall", perf_wb_stall, 32'(tv[i].stall));
`endif
    end
    cmd_num_row = 16'd4; cmd_k_tiles = 8'd2; cmd_n_tiles = 8'd1;
    cmd_in_base = '0; cmd_w_base = '0; cmd_out_base = '0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("r_t1", 32'(cc_en), 32'd1);
    tick();
    cc_sys_done = 1'b1;
    tick();
    cc_sys_done = 1'b0;
    chk("r_t2", 32'({cc_en, cc_in_addr}), 32'({1'b1, 16'h0004}));
    tick();
    chk("r_wait", 32'({busy, cc_en}), 32'b10);
    rstn = 1'b0;
    #1;
    chk("arst_ctl", 32'({cmd_ready, cc_en, cc_weight_fill, cc_weight_change, cc_accum_clear, wb_valid, busy, done}), 32'd0);
    chk("arst_addr", 32'({cc_in_addr, cc_w_addr}), 32'd0);
    chk("arst_wb", 32'({wb_addr, cc_num_row}), 32'd0);
    repeat (3) begin
      tick();
      chk("arst_no_done", 32'(done), 32'd0);
    end
    rstn = 1'b1;
    tick();
    chk("post_rst_idle", 32'({cmd_ready, busy, done}), 32'b100);
    run(tv[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
